// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one synchronous-read memory port between instruction fetch,
//   data load and data store for the LC-3 pipeline.
//   Fixed priority store > load > fetch. While locked (indirect load in
//   progress) only the load side may be granted.
//   Optional fetch anti-starvation override, enabled by defining
//   MEM_ARB_STARVE_EN: after STARVE_LIMIT consecutive denied fetch cycles
//   fetch is promoted above store and load (only while UNLOCKED).
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   f_req/f_addr               fetch request and address
//   f_gnt/f_rvalid/f_rdata     fetch grant, read valid, read data
//   l_req/l_addr/l_lock        load request, address, keep-port-after-grant
//   l_gnt/l_rvalid/l_rdata     load grant, read valid, read data
//   s_req/s_addr/s_wdata       store request, address, data
//   s_gnt                      store grant
//   mem_en/mem_we              memory access / write enable
//   mem_addr/mem_wdata         memory address / write data
//   mem_rdata                  memory read data (one cycle after a read)

module mem_port_arbiter #(
  parameter int unsigned AW           = 16,
  parameter int unsigned DW           = 16,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_gnt,
  output logic          f_rvalid,
  output logic [DW-1:0] f_rdata,
  input  logic          l_req,
  input  logic [AW-1:0] l_addr,
  input  logic          l_lock,
  output logic          l_gnt,
  output logic          l_rvalid,
  output logic [DW-1:0] l_rdata,
  input  logic          s_req,
  input  logic [AW-1:0] s_addr,
  input  logic [DW-1:0] s_wdata,
  output logic          s_gnt,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } state_t;

  state_t state;
  logic   override;

`ifdef MEM_ARB_STARVE_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!f_req || f_gnt) begin
      starve_cnt <= '0;
    end else if (starve_cnt != LIMIT) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  assign override = (starve_cnt == LIMIT) && (state == UNLOCKED);
`else
  logic unused_starve_cfg;
  assign unused_starve_cfg = ^(4'(STARVE_LIMIT));
  assign override = 1'b0;
`endif

  // Grants are combinational so a winning request is served the same cycle;
  // gating with rst_n keeps the port quiet while reset is asserted.
  always_comb begin
    f_gnt = 1'b0;
    l_gnt = 1'b0;
    s_gnt = 1'b0;
    if (rst_n) begin
      if (state == LOCKED) begin
        l_gnt = l_req;
      end else if (override && f_req) begin
        f_gnt = 1'b1;
      end else if (s_req) begin
        s_gnt = 1'b1;
      end else if (l_req) begin
        l_gnt = 1'b1;
      end else if (f_req) begin
        f_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    if (s_gnt) begin
      mem_addr  = s_addr;
      mem_wdata = s_wdata;
    end else if (l_gnt) begin
      mem_addr = l_addr;
    end else if (f_gnt) begin
      mem_addr = f_addr;
    end
  end

  assign mem_en = f_gnt | l_gnt | s_gnt;
  assign mem_we = s_gnt;

  // Lock FSM plus the registered read-owner tags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= UNLOCKED;
      f_rvalid <= 1'b0;
      l_rvalid <= 1'b0;
    end else begin
      f_rvalid <= f_gnt;
      l_rvalid <= l_gnt;
      case (state)
        UNLOCKED: if (l_gnt && l_lock)  state <= LOCKED;
        LOCKED:   if (l_gnt && !l_lock) state <= UNLOCKED;
        default:  state <= UNLOCKED;
      endcase
    end
  end

  assign f_rdata = f_rvalid ? mem_rdata : '0;
  assign l_rdata = l_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed steps, a small synchronous-read
// memory, and a queue of expected read responses.

module tb_mem_port_arbiter;

  localparam logic [1:0] G_NONE = 2'd0;
  localparam logic [1:0] G_F    = 2'd1;
  localparam logic [1:0] G_L    = 2'd2;
  localparam logic [1:0] G_S    = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        f_req, l_req, l_lock, s_req;
  logic [15:0] f_addr, l_addr, s_addr, s_wdata;
  logic        f_gnt, f_rvalid, l_gnt, l_rvalid, s_gnt, mem_en, mem_we;
  logic [15:0] f_rdata, l_rdata, mem_addr, mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic [15:0] mem [256];

  typedef struct {
    bit          is_load;
    logic [15:0] data;
  } rd_t;
  rd_t q[$];

  int unsigned total  = 0;
  int unsigned passed = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(16), .DW(16), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .l_req(l_req), .l_addr(l_addr), .l_lock(l_lock), .l_gnt(l_gnt), .l_rvalid(l_rvalid),
    .l_rdata(l_rdata),
    .s_req(s_req), .s_addr(s_addr), .s_wdata(s_wdata), .s_gnt(s_gnt),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[7:0]];
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock cycle: drive requests after the falling edge, then check the
  // response owed from the previous cycle and this cycle's grant/port values.
  task automatic cyc(input logic f, input logic [15:0] fa,
                     input logic l, input logic [15:0] la, input logic lk,
                     input logic s, input logic [15:0] sa, input logic [15:0] sd,
                     input logic [1:0] eg, input logic [15:0] ed);
    rd_t         r;
    logic [2:0]  exp_g;
    logic [15:0] exp_a, exp_d;
    @(negedge clk);
    f_req = f; f_addr = fa;
    l_req = l; l_addr = la; l_lock = lk;
    s_req = s; s_addr = sa; s_wdata = sd;
    #1;
    if (q.size() > 0) begin
      r = q.pop_front();
      chk("f_rvalid", f_rvalid, !r.is_load);
      chk("l_rvalid", l_rvalid, r.is_load);
      if (r.is_load) chk("l_rdata", l_rdata, r.data);
      else           chk("f_rdata", f_rdata, r.data);
    end else begin
      chk("f_rvalid_idle", f_rvalid, 1'b0);
      chk("l_rvalid_idle", l_rvalid, 1'b0);
      chk("rdata_idle", {f_rdata, l_rdata}, 32'h0);
    end
    exp_a = '0;
    exp_d = '0;
    case (eg)
      G_F:     begin exp_g = 3'b100; exp_a = fa; end
      G_L:     begin exp_g = 3'b010; exp_a = la; end
      G_S:     begin exp_g = 3'b001; exp_a = sa; exp_d = sd; end
      default: exp_g = 3'b000;
    endcase
    chk("gnt_fls", {f_gnt, l_gnt, s_gnt}, exp_g);
    chk("mem_en_we", {mem_en, mem_we}, {eg != G_NONE, eg == G_S});
    chk("mem_addr", mem_addr, exp_a);
    chk("mem_wdata", mem_wdata, exp_d);
    if (eg == G_F) q.push_back('{is_load: 1'b0, data: ed});
    if (eg == G_L) q.push_back('{is_load: 1'b1, data: ed});
  endtask

  task automatic idle();
    cyc(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, G_NONE, 16'h0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h00] = 16'h5555;
    mem[8'h03] = 16'h1234;
    mem[8'h20] = 16'h0030;
    mem[8'h30] = 16'hCAFE;

    // Reset with every requester asserted: nothing may leak out.
    rst_n = 1'b1;
    f_req = 1'b1; f_addr = 16'h3;
    l_req = 1'b1; l_addr = 16'h20; l_lock = 1'b1;
    s_req = 1'b1; s_addr = 16'h10; s_wdata = 16'hBEEF;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_outputs",
        {f_gnt, l_gnt, s_gnt, mem_en, mem_we, f_rvalid, l_rvalid,
         f_rdata, l_rdata, mem_addr, mem_wdata}, 128'h0);
    f_req = 1'b0; l_req = 1'b0; l_lock = 1'b0; s_req = 1'b0;
    #9 rst_n = 1'b1;

    // Fetch only.
    cyc(1'b1, 16'h0003, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, G_F, 16'h1234);
    idle();

    // All three: store, then load of the stored word, then fetch.
    cyc(1'b1, 16'h0000, 1'b1, 16'h0010, 1'b0, 1'b1, 16'h0010, 16'hBEEF, G_S, 16'h0);
    cyc(1'b1, 16'h0000, 1'b1, 16'h0010, 1'b0, 1'b0, 16'h0, 16'h0, G_L, 16'hBEEF);
    cyc(1'b1, 16'h0000, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, G_F, 16'h5555);
    idle();

    // Indirect load with lock; store/fetch held off until the lock releases.
    cyc(1'b0, 16'h0000, 1'b1, 16'h0020, 1'b1, 1'b0, 16'h0, 16'h0, G_L, 16'h0030);
    cyc(1'b1, 16'h0000, 1'b0, 16'h0, 1'b0, 1'b1, 16'h0040, 16'h1111, G_NONE, 16'h0);
    cyc(1'b1, 16'h0000, 1'b1, 16'h0030, 1'b0, 1'b1, 16'h0040, 16'h1111, G_L, 16'hCAFE);
    cyc(1'b1, 16'h0000, 1'b0, 16'h0, 1'b0, 1'b1, 16'h0040, 16'h1111, G_S, 16'h0);
    cyc(1'b1, 16'h0000, 1'b1, 16'h0040, 1'b0, 1'b0, 16'h0, 16'h0, G_L, 16'h1111);
    cyc(1'b1, 16'h0000, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, G_F, 16'h5555);
    idle();

    // Continuous store traffic against a waiting fetch.
`ifdef MEM_ARB_STARVE_EN
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 16'h0003, 1'b0, 16'h0, 1'b0, 1'b1, 16'h0050, 16'(i), G_S, 16'h0);
    cyc(1'b1, 16'h0003, 1'b0, 16'h0, 1'b0, 1'b1, 16'h0050, 16'h0009, G_F, 16'h1234);
    cyc(1'b0, 16'h0000, 1'b0, 16'h0, 1'b0, 1'b1, 16'h0050, 16'h0009, G_S, 16'h0);
`else
    for (int i = 0; i < 20; i++)
      cyc(1'b1, 16'h0003, 1'b0, 16'h0, 1'b0, 1'b1, 16'h0050, 16'(i), G_S, 16'h0);
    cyc(1'b1, 16'h0003, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, G_F, 16'h1234);
`endif
    idle();

    // Async reset while LOCKED with a read response in flight.
    cyc(1'b0, 16'h0000, 1'b1, 16'h0020, 1'b1, 1'b0, 16'h0, 16'h0, G_L, 16'h0030);
    @(posedge clk);
    #2;
    chk("l_rvalid_pre_reset", l_rvalid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("reset_mid_locked",
        {f_gnt, l_gnt, s_gnt, mem_en, mem_we, f_rvalid, l_rvalid,
         f_rdata, l_rdata, mem_addr, mem_wdata}, 128'h0);
    q.delete();
    l_req = 1'b0; l_lock = 1'b0;
    #1 rst_n = 1'b1;
    cyc(1'b0, 16'h0000, 1'b0, 16'h0, 1'b0, 1'b1, 16'h0060, 16'h2222, G_S, 16'h0);
    cyc(1'b0, 16'h0000, 1'b1, 16'h0060, 1'b0, 1'b0, 16'h0, 16'h0, G_L, 16'h2222);
    idle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
